// File: rtl/ibex_fetch_align_fifo.sv
// Fetch alignment buffer: stores word-aligned fetch responses and presents
// each instruction starting at bit 0, together with its PC and fault status.
// A 32-bit instruction that starts in the upper half of a word is stitched
// together from the two oldest stored words.
module ibex_fetch_align_fifo #(
  parameter int DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Word storage; contents need no reset because count_reg says what is live.
  logic [31:0] mem_data [DEPTH];
  logic        mem_err  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd1_ptr;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      addr_reg, addr_next;

  logic [31:0] w0_data, w1_data;
  logic        w0_err, w1_err;
  logic        has1, has2;
  logic        unaligned, w0_upper_full;
  logic        is_comp, fire, pop, push;

  // Oldest and next-oldest words, plus the derived alignment view.
  always_comb begin
    rd1_ptr       = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    w0_data       = mem_data[rd_ptr_reg];
    w0_err        = mem_err[rd_ptr_reg];
    w1_data       = mem_data[rd1_ptr];
    w1_err        = mem_err[rd1_ptr];
    has1          = (count_reg != '0);
    has2          = (count_reg >= CNT_TWO);
    unaligned     = addr_reg[1];
    w0_upper_full = (w0_data[17:16] == 2'b11);
  end

  // Output view. An unaligned 32-bit instruction with a faulted first half is
  // released immediately so the fault is not stuck waiting for a second word.
  always_comb begin
    in_ready_o = (count_reg < CNT_FULL);
    out_addr_o = addr_reg;
    if (!unaligned) begin
      out_rdata_o = w0_data;
      out_valid_o = has1;
      out_err_o   = has1 & w0_err;
    end else begin
      out_rdata_o = {(has2 ? w1_data[15:0] : 16'h0000), w0_data[31:16]};
      if (!w0_upper_full) begin
        out_valid_o = has1;
        out_err_o   = has1 & w0_err;
      end else begin
        out_valid_o = has2 | (has1 & w0_err);
        out_err_o   = has1 & (w0_err | (has2 & w1_err));
      end
    end
  end

  // Handshakes. A word is retired once its last halfword has been consumed:
  // aligned compressed leaves the upper half still pending.
  always_comb begin
    is_comp = (out_rdata_o[1:0] != 2'b11);
    fire    = out_valid_o & out_ready_i & ~clear_i;
    pop     = fire & (unaligned | ~is_comp);
    push    = in_valid_i & in_ready_o & ~clear_i;
  end

  // Next-state for pointers, occupancy and PC; clear overrides everything.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    addr_next   = addr_reg;
    if (clear_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
      addr_next   = {clear_addr_i[31:1], 1'b0};
    end else begin
      if (pop) begin
        rd_ptr_next = rd1_ptr;
      end
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
      if (fire) begin
        addr_next = addr_reg + (is_comp ? 32'd2 : 32'd4);
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      addr_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      addr_reg   <= addr_next;
    end
  end

  // Storage write at the tail.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= in_rdata_i;
      mem_err[wr_ptr_reg]  <= in_err_i;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Bench for ibex_fetch_align_fifo: directed scenarios with literal
// expectations, then a randomized run against a queue-based model.
module tb_ibex_fetch_align_fifo;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [31:0] clear_addr;
  logic        in_valid;
  logic [31:0] in_rdata;
  logic        in_err;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [31:0] out_addr;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  // Model: queue of {err, data} words and the PC of the next instruction.
  logic [32:0] q [$];
  logic [31:0] m_addr;
  logic        e_valid, e_err, e_ready;
  logic [31:0] e_rdata;

  ibex_fetch_align_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .clear_addr_i(clear_addr),
    .in_valid_i(in_valid), .in_rdata_i(in_rdata), .in_err_i(in_err),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rdata_o(out_rdata), .out_addr_o(out_addr), .out_err_o(out_err)
  );

  always #5 clk = ~clk;

  // What the outputs must be, from the halfword stream held in the queue.
  function automatic void model_outputs();
    int n;
    logic [32:0] w0, w1;
    n  = q.size();
    w0 = '0;
    w1 = '0;
    if (n > 0) w0 = q[0];
    if (n > 1) w1 = q[1];
    e_ready = (n < DEPTH);
    if (!m_addr[1]) begin
      e_rdata = w0[31:0];
      e_valid = (n >= 1);
      e_err   = (n >= 1) && w0[32];
    end else begin
      e_rdata = {((n >= 2) ? w1[15:0] : 16'h0000), w0[31:16]};
      if (w0[17:16] != 2'b11) begin
        e_valid = (n >= 1);
        e_err   = (n >= 1) && w0[32];
      end else begin
        e_valid = (n >= 2) || ((n >= 1) && w0[32]);
        e_err   = (n >= 1) && (w0[32] || ((n >= 2) && w1[32]));
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    model_outputs();
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_addr", out_addr, m_addr);
    if (e_valid) begin
      chk("out_rdata", out_rdata, e_rdata);
      chk("out_err", 32'(out_err), 32'(e_err));
    end
  endtask

  // One clock: drive at negedge, advance the model, compare after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic e,
                      input logic r, input logic c, input logic [31:0] ca);
    logic fire, comp, was_un, push;
    @(negedge clk);
    in_valid = v; in_rdata = d; in_err = e; out_ready = r;
    clear = c; clear_addr = ca;
    model_outputs();
    if (c) begin
      q.delete();
      m_addr = {ca[31:1], 1'b0};
    end else begin
      fire   = e_valid && r;
      push   = v && e_ready;
      comp   = (e_rdata[1:0] != 2'b11);
      was_un = m_addr[1];
      if (fire) begin
        m_addr = m_addr + (comp ? 32'd2 : 32'd4);
        if (was_un || !comp) void'(q.pop_front());
      end
      if (push) q.push_back({e, d});
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();                                step(0, 0, 0, 0, 0, 0); endtask
  task automatic push_w(input logic [31:0] d, input logic e); step(1, d, e, 0, 0, 0); endtask
  task automatic consume();                             step(0, 0, 0, 1, 0, 0); endtask
  task automatic clr(input logic [31:0] a);             step(0, 0, 0, 0, 1, a); endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_addr"}, out_addr, 32'd0);
    chk({tag, "_err"}, 32'(out_err), 32'd0);
  endtask

  initial begin
    logic v, e, r, c;
    logic [31:0] d, ca;
    rst = 1'b1; clear = 0; clear_addr = 0; in_valid = 0; in_rdata = 0;
    in_err = 0; out_ready = 0;
    m_addr = 0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Aligned 32-bit instruction.
    clr(32'h100);
    push_w(32'h00A00093, 0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_rdata", out_rdata, 32'h00A00093);
    chk("t1_addr", out_addr, 32'h100);
    consume();
    chk("t1_empty", 32'(out_valid), 32'd0);
    chk("t1_addr_next", out_addr, 32'h104);

    // Two compressed instructions in one word.
    clr(32'h200);
    push_w(32'h45054501, 0);
    chk("t2_lo", {16'h0, out_rdata[15:0]}, 32'h4501);
    chk("t2_addr_lo", out_addr, 32'h200);
    consume();
    chk("t2_hi_valid", 32'(out_valid), 32'd1);
    chk("t2_hi", {16'h0, out_rdata[15:0]}, 32'h4505);
    chk("t2_addr_hi", out_addr, 32'h202);
    consume();
    chk("t2_empty", 32'(out_valid), 32'd0);
    chk("t2_addr_end", out_addr, 32'h204);

    // 32-bit instruction split across two words after an unaligned clear.
    clr(32'h302);
    push_w(32'h00931234, 0);
    chk("t3_wait", 32'(out_valid), 32'd0);
    push_w(32'h000000A0, 0);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_rdata", out_rdata, 32'h00A00093);
    chk("t3_addr", out_addr, 32'h302);
    consume();
    chk("t3_addr_next", out_addr, 32'h306);

    // Fill with the consumer stalled, then drain and refill.
    clr(32'h500);
    push_w(32'h00100093, 0);
    push_w(32'h00200093, 0);
    push_w(32'h00300093, 0);
    chk("t4_full", 32'(in_ready), 32'd0);
    step(1, 32'h00400093, 0, 0, 0, 0);
    chk("t4_stable", out_rdata, 32'h00100093);
    step(1, 32'h00400093, 0, 1, 0, 0);
    chk("t4_after_pop", out_rdata, 32'h00200093);
    chk("t4_ready", 32'(in_ready), 32'd1);
    step(1, 32'h00500093, 0, 1, 0, 0);
    chk("t4_poppush", out_rdata, 32'h00300093);
    chk("t4_pp_ready", 32'(in_ready), 32'd1);
    push_w(32'h00600093, 0);
    chk("t4_refull", 32'(in_ready), 32'd0);

    // Faulted first half of an unaligned 32-bit instruction.
    clr(32'h402);
    push_w(32'h00030000, 1);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_err", 32'(out_err), 32'd1);
    chk("t5_addr", out_addr, 32'h402);
    consume();
    chk("t5_drained", 32'(out_valid), 32'd0);
    chk("t5_addr_next", out_addr, 32'h406);

    // Push in the same cycle as a clear is dropped.
    step(1, 32'h00A00093, 0, 1, 1, 32'h600);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_addr", out_addr, 32'h600);
    idle();
    chk("t6_still_empty", 32'(out_valid), 32'd0);

    // PC wraps past the top of the address space.
    clr(32'hFFFFFFFC);
    push_w(32'h45054501, 0);
    consume();
    chk("t7_addr_top", out_addr, 32'hFFFFFFFE);
    consume();
    chk("t7_addr_wrap", out_addr, 32'h0);

    // Asynchronous reset in the middle of a split instruction.
    clr(32'h702);
    push_w(32'h00930000, 0);
    push_w(32'h000000A0, 0);
    @(negedge clk);
    in_valid = 0; out_ready = 0; clear = 0;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_addr = 0;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    clr(32'h1000);
    for (int i = 0; i < 3000; i++) begin
      c  = ($urandom_range(0, 29) == 0);
      ca = $urandom;
      ca[0] = 1'b0;
      v  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 6);
      e  = ($urandom_range(0, 15) == 0);
      d  = $urandom;
      if ($urandom_range(0, 1) == 1) d[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) d[17:16] = 2'b11;
      step(v, d, e, r, c, ca);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
